// File: rtl/adc_capture_buffer.sv
`default_nettype none
// ============================================================================
// Module      : adc_capture_buffer
// Description : ADC frame capture. Converts offset-binary samples to two's
//               complement, waits for an armed rising level crossing or a
//               forced trigger, then stores a decimated 2^ADDR_W-sample frame
//               in a simple dual-port RAM with a registered read port.
//               Optional build macro: ADC_CAP_OTR_TAG_EN stores the
//               out-of-range flag with each sample and returns it in
//               rd_data[15].
// Revision    : 1.0 - initial release
// ============================================================================
module adc_capture_buffer #(
  parameter int DATA_W  = 14,
  parameter int ADDR_W  = 10,
  parameter int DECIM_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  adc_da,
  input  logic               adc_otr,
  input  logic               arm,
  input  logic               force_trig,
  input  logic [DATA_W-1:0]  trig_level,
  input  logic [DECIM_W-1:0] decim,
  output logic               busy,
  output logic               done,
  output logic [15:0]        otr_count,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [15:0]        rd_data
);

`ifdef ADC_CAP_OTR_TAG_EN
  localparam int c_mem_w = DATA_W + 1;
`else
  localparam int c_mem_w = DATA_W;
`endif
  localparam int                c_depth     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] c_last_addr = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t                    state_q;
  logic signed [DATA_W-1:0]  s_q;
  logic signed [DATA_W-1:0]  s_prev_q;
  logic                      otr_q;
  logic [ADDR_W-1:0]         wr_addr_q;
  logic [DECIM_W-1:0]        dec_cnt_q;
  logic [DECIM_W-1:0]        decim_q;
  logic                      busy_q;
  logic                      done_q;
  logic [15:0]               otr_count_q;
  logic [15:0]               rd_data_q;
  logic [c_mem_w-1:0]        mem_q [c_depth];

  logic                      w_cross;
  logic [DECIM_W-1:0]        w_decim_eff;
  logic                      w_wr_en;
  logic [ADDR_W-1:0]         w_wr_addr;
  logic [c_mem_w-1:0]        w_wr_data;
  logic [c_mem_w-1:0]        w_rd_raw;
  logic [15:0]               w_rd_word;

  // Input stage: offset binary to two's complement (flip MSB), plus history
  always_ff @(posedge clk) begin
    if (reset) begin
      s_q      <= '0;
      s_prev_q <= '0;
      otr_q    <= 1'b0;
    end else begin
      s_q      <= {~adc_da[DATA_W-1], adc_da[DATA_W-2:0]};
      s_prev_q <= s_q;
      otr_q    <= adc_otr;
    end
  end

  assign w_cross     = (s_prev_q < $signed(trig_level)) && (s_q >= $signed(trig_level));
  assign w_decim_eff = (decim == '0) ? DECIM_W'(1) : decim;

  // Write strobe: trigger cycle writes address 0, capture writes on counter 0
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = wr_addr_q;
    if (!reset) begin
      case (state_q)
        ST_ARMED: begin
          if (!arm && (w_cross || force_trig)) begin
            w_wr_en   = 1'b1;
            w_wr_addr = '0;
          end
        end
        ST_CAPTURE: w_wr_en = (dec_cnt_q == '0);
        default:    w_wr_en = 1'b0;
      endcase
    end
  end

  // Control FSM with registered status outputs and OTR counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_addr_q   <= '0;
      dec_cnt_q   <= '0;
      decim_q     <= '0;
      otr_count_q <= '0;
    end else begin
      if (w_wr_en && otr_q && (otr_count_q != 16'hFFFF)) begin
        otr_count_q <= otr_count_q + 16'd1;
      end
      case (state_q)
        ST_IDLE, ST_DONE, ST_ARMED: begin
          if (arm) begin
            // Arm (or re-arm) always wins over a trigger in the same cycle
            state_q     <= ST_ARMED;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            wr_addr_q   <= '0;
            dec_cnt_q   <= '0;
            otr_count_q <= '0;
          end else if ((state_q == ST_ARMED) && (w_cross || force_trig)) begin
            state_q   <= ST_CAPTURE;
            wr_addr_q <= ADDR_W'(1);
            dec_cnt_q <= (w_decim_eff == DECIM_W'(1)) ? '0 : DECIM_W'(1);
            decim_q   <= w_decim_eff;
          end
        end
        ST_CAPTURE: begin
          dec_cnt_q <= (dec_cnt_q == decim_q - DECIM_W'(1)) ? '0 : dec_cnt_q + DECIM_W'(1);
          if (w_wr_en) begin
            wr_addr_q <= wr_addr_q + ADDR_W'(1);
            if (wr_addr_q == c_last_addr) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef ADC_CAP_OTR_TAG_EN
  assign w_wr_data = {otr_q, s_q};
  assign w_rd_word = {w_rd_raw[DATA_W], 15'($signed(w_rd_raw[DATA_W-1:0]))};
`else
  assign w_wr_data = s_q;
  assign w_rd_word = 16'($signed(w_rd_raw));
`endif

  // RAM write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      mem_q[w_wr_addr] <= w_wr_data;
    end
  end

  assign w_rd_raw = mem_q[rd_addr];

  // Registered read port; a same-address write returns the old word
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= w_rd_word;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign otr_count = otr_count_q;
  assign rd_data   = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_capture_buffer
// Description : Directed self-checking bench for adc_capture_buffer.
//               Honours the ADC_CAP_OTR_TAG_EN build macro for readback values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_capture_buffer;

  localparam int DATA_W  = 14;
  localparam int ADDR_W  = 10;
  localparam int DECIM_W = 8;

`ifdef ADC_CAP_OTR_TAG_EN
  localparam logic [15:0] EXP_HI = 16'h8007;
  localparam logic [15:0] EXP_LO = 16'h7FFD;
`else
  localparam logic [15:0] EXP_HI = 16'h0007;
  localparam logic [15:0] EXP_LO = 16'hFFFD;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic [DATA_W-1:0]  adc_da;
  logic               adc_otr;
  logic               arm;
  logic               force_trig;
  logic [DATA_W-1:0]  trig_level;
  logic [DECIM_W-1:0] decim;
  logic               busy;
  logic               done;
  logic [15:0]        otr_count;
  logic [ADDR_W-1:0]  rd_addr;
  logic [15:0]        rd_data;

  int n_cmp = 0;
  int n_err = 0;

  adc_capture_buffer #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DECIM_W(DECIM_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .adc_da    (adc_da),
    .adc_otr   (adc_otr),
    .arm       (arm),
    .force_trig(force_trig),
    .trig_level(trig_level),
    .decim     (decim),
    .busy      (busy),
    .done      (done),
    .otr_count (otr_count),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  // One rising edge, then settle so outputs are sampled away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; adc_da = 14'h2000; adc_otr = 1'b0; arm = 1'b0; force_trig = 1'b0;
    trig_level = '0; decim = 8'd1; rd_addr = '0;
    tick(); tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (otr_count !== 16'h0) begin n_err++; $display("FAIL reset_otr: got %h want 0000", otr_count); end
    n_cmp++; if (rd_data !== 16'h0) begin n_err++; $display("FAIL reset_rd_data: got %h want 0000", rd_data); end
    reset = 1'b0;
    tick(); tick();
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL idle_after_reset: busy=%b done=%b want 0 0", busy, done); end
  endtask

  // Ramp through zero with level 0 and decim 1: RAM[k] = k
  task automatic test_ramp_trigger();
    int addrs[6] = '{0, 1, 2, 255, 256, 1023};
    trig_level = '0; decim = 8'd1; adc_da = 14'h1F00; arm = 1'b1;
    tick();
    arm = 1'b0;
    n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL ramp_armed: busy=%b done=%b want 1 0", busy, done); end
    for (int v = 'h1F01; v <= 'h2000; v++) begin
      adc_da = v[13:0];
      tick();
    end
    for (int m = 1; m <= 1024; m++) begin
      adc_da = 14'(32'h2000 + m);
      tick();
      if (m == 1023) begin
        n_cmp++; if (done !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL ramp_before_done: done=%b busy=%b want 0 1", done, busy); end
      end
      if (m == 1024) begin
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL ramp_done: done=%b busy=%b want 1 0", done, busy); end
      end
    end
    foreach (addrs[i]) begin
      rd_addr = addrs[i][ADDR_W-1:0];
      tick();
      n_cmp++; if (rd_data !== 16'(addrs[i])) begin n_err++; $display("FAIL ramp_ram[%0d]: got %h want %h", addrs[i], rd_data, 16'(addrs[i])); end
    end
  endtask

  // Forced trigger with decim 4: RAM[k] = 4k+9, done 4093 cycles after trigger
  task automatic test_decim4();
    trig_level = 14'h1FFF; decim = 8'd4; adc_da = 14'h2009; arm = 1'b1;
    tick();
    arm = 1'b0;
    n_cmp++; if (done !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL decim_rearm: done=%b busy=%b want 0 1", done, busy); end
    adc_da = 14'h200A; force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
    for (int m = 1; m <= 4092; m++) begin
      adc_da = 14'(32'h200A + m);
      if (m == 10) decim = 8'd1;   // must not affect the running frame
      tick();
      if (m == 4091) begin
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL decim_early_done: got %b want 0", done); end
      end
      if (m == 4092) begin
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL decim_done: got %b want 1", done); end
      end
    end
    rd_addr = 10'd0; tick();
    n_cmp++; if (rd_data !== 16'd9) begin n_err++; $display("FAIL decim_ram0: got %h want %h", rd_data, 16'd9); end
    rd_addr = 10'd1; tick();
    n_cmp++; if (rd_data !== 16'd13) begin n_err++; $display("FAIL decim_ram1: got %h want %h", rd_data, 16'd13); end
    rd_addr = 10'd1023; tick();
    n_cmp++; if (rd_data !== 16'd4101) begin n_err++; $display("FAIL decim_ram1023: got %h want %h", rd_data, 16'd4101); end
    n_cmp++; if (otr_count !== 16'd0) begin n_err++; $display("FAIL decim_otr: got %h want 0000", otr_count); end
  endtask

  // OTR high on samples 100..109 (value +7), all others -3
  task automatic test_otr_count();
    int n_hi, n_lo, first_hi, last_hi;
    n_hi = 0; n_lo = 0; first_hi = -1; last_hi = -1;
    trig_level = 14'h1FFF; decim = 8'd1; adc_otr = 1'b0; adc_da = 14'h1FFD; arm = 1'b1;
    tick();
    arm = 1'b0; force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
    for (int k = 2; k <= 1024; k++) begin
      adc_otr = (k >= 100 && k < 110);
      adc_da  = adc_otr ? 14'h2007 : 14'h1FFD;
      tick();
    end
    adc_otr = 1'b0;
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL otr_done: got %b want 1", done); end
    n_cmp++; if (otr_count !== 16'd10) begin n_err++; $display("FAIL otr_count: got %0d want 10", otr_count); end
    for (int a = 0; a < 1024; a++) begin
      rd_addr = a[ADDR_W-1:0];
      tick();
      if (rd_data === EXP_HI) begin
        n_hi++;
        if (first_hi < 0) first_hi = a;
        last_hi = a;
      end else if (rd_data === EXP_LO) begin
        n_lo++;
      end
    end
    n_cmp++; if (n_hi != 10) begin n_err++; $display("FAIL otr_tagged_words: got %0d want 10 of %h", n_hi, EXP_HI); end
    n_cmp++; if (n_lo != 1014) begin n_err++; $display("FAIL otr_plain_words: got %0d want 1014 of %h", n_lo, EXP_LO); end
    n_cmp++; if (first_hi != 100 || last_hi != 109) begin n_err++; $display("FAIL otr_addresses: got %0d..%0d want 100..109", first_hi, last_hi); end
    arm = 1'b1;
    tick();
    arm = 1'b0;
    n_cmp++; if (otr_count !== 16'd0 || done !== 1'b0) begin n_err++; $display("FAIL otr_clear_on_arm: otr=%0d done=%b want 0 0", otr_count, done); end
  endtask

  // arm+force together: arm wins; arm mid-capture ignored; force in DONE ignored
  task automatic test_arm_force_same();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    trig_level = 14'h1FFF; decim = 8'd1;
    adc_da = 14'h2014; arm = 1'b1; force_trig = 1'b1;
    tick();
    arm = 1'b0;
    n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL af_armed: busy=%b done=%b want 1 0", busy, done); end
    adc_da = 14'h2015;
    tick();
    force_trig = 1'b0;
    for (int k = 2; k <= 1024; k++) begin
      adc_da = 14'(32'h2014 + k);
      arm = (k == 500);
      tick();
      arm = 1'b0;
      if (k == 1023) begin
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL af_early_done: got %b want 0", done); end
      end
      if (k == 1024) begin
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL af_done: done=%b busy=%b want 1 0", done, busy); end
      end
    end
    rd_addr = 10'd0; tick();
    n_cmp++; if (rd_data !== 16'd20) begin n_err++; $display("FAIL af_ram0: got %h want %h", rd_data, 16'd20); end
    rd_addr = 10'd500; tick();
    n_cmp++; if (rd_data !== 16'd520) begin n_err++; $display("FAIL af_ram500: got %h want %h", rd_data, 16'd520); end
    rd_addr = 10'd1023; tick();
    n_cmp++; if (rd_data !== 16'd1043) begin n_err++; $display("FAIL af_ram1023: got %h want %h", rd_data, 16'd1043); end
    force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
    tick();
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL af_force_in_done: done=%b busy=%b want 1 0", done, busy); end
  endtask

  // Reset at write address 300, partial frame preserved, restart from address 0
  task automatic test_reset_mid_capture();
    trig_level = 14'h1FFF; decim = 8'd1;
    adc_da = 14'h2000; arm = 1'b1;
    tick();
    arm = 1'b0; adc_da = 14'h2002; force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
    for (int k = 2; k <= 300; k++) begin
      adc_da = 14'(32'h2000 + 2 * k);
      tick();
    end
    reset = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL rst_mid_state: busy=%b done=%b want 0 0", busy, done); end
    reset = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL rst_mid_idle: busy=%b done=%b want 0 0", busy, done); end
    rd_addr = 10'd0; tick();
    n_cmp++; if (rd_data !== 16'd0) begin n_err++; $display("FAIL rst_ram0: got %h want %h", rd_data, 16'd0); end
    rd_addr = 10'd150; tick();
    n_cmp++; if (rd_data !== 16'd300) begin n_err++; $display("FAIL rst_ram150: got %h want %h", rd_data, 16'd300); end
    rd_addr = 10'd299; tick();
    n_cmp++; if (rd_data !== 16'd598) begin n_err++; $display("FAIL rst_ram299: got %h want %h", rd_data, 16'd598); end
    rd_addr = 10'd300; tick();
    n_cmp++; if (rd_data !== 16'd320) begin n_err++; $display("FAIL rst_ram300: got %h want %h", rd_data, 16'd320); end
    adc_da = 14'h204D; arm = 1'b1;
    tick();
    arm = 1'b0; force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
    rd_addr = 10'd0; tick();
    n_cmp++; if (rd_data !== 16'd77) begin n_err++; $display("FAIL restart_ram0: got %h want %h", rd_data, 16'd77); end
    rd_addr = 10'd2; tick();
    n_cmp++; if (rd_data !== 16'd4) begin n_err++; $display("FAIL restart_collision_old: got %h want %h", rd_data, 16'd4); end
    rd_addr = 10'd2; tick();
    n_cmp++; if (rd_data !== 16'd77) begin n_err++; $display("FAIL restart_ram2: got %h want %h", rd_data, 16'd77); end
    rd_addr = 10'd500; tick();
    n_cmp++; if (rd_data !== 16'd520) begin n_err++; $display("FAIL restart_ram500: got %h want %h", rd_data, 16'd520); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL restart_busy: got %b want 1", busy); end
  endtask

  initial begin
    test_reset();
    test_ramp_trigger();
    test_decim4();
    test_otr_count();
    test_arm_force_same();
    test_reset_mid_capture();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
